// File: rtl/led_xmit.sv
`default_nettype none
// ============================================================================
// led_xmit -- pulse-width-coded IR/LED byte transmitter, LSB first, 38 kHz carrier
// Rev 1.0
// ============================================================================
module led_xmit #(
   parameter int BIT_PERIOD   = 84000,
   parameter int ONE_MARK     = 60000,
   parameter int ZERO_MARK    = 20000,
   parameter int GAP_CYCLES   = 100000,
   parameter int CARRIER_HALF = 1316
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [7:0] DATA_IN,
   input  logic       SEND,
   output logic       BUSY,
   output logic       DONE,
   output logic       MARK_ENV,
   output logic       LED_OUT
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_MARK  = 2'd1;
   localparam logic [1:0] S_SPACE = 2'd2;
   localparam logic [1:0] S_GAP   = 2'd3;

   localparam logic [31:0] C_ONE_LAST  = 32'(ONE_MARK - 1);
   localparam logic [31:0] C_ZERO_LAST = 32'(ZERO_MARK - 1);
   localparam logic [31:0] C_BP_LAST   = 32'(BIT_PERIOD - 1);
   localparam logic [31:0] C_GAP_LAST  = 32'(GAP_CYCLES - 1);

   logic [1:0]  state_q,  state_d;
   logic [7:0]  shift_q,  shift_d;
   logic [2:0]  bitcnt_q, bitcnt_d;
   logic [31:0] per_q,    per_d;
   logic [31:0] car_q,    car_d;
   logic        mark_q,   mark_d;
   logic        led_q,    led_d;
   logic        busy_q,   busy_d;
   logic        done_q,   done_d;
   logic [31:0] mark_last;

   assign mark_last = shift_q[0] ? C_ONE_LAST : C_ZERO_LAST;

   // The period counter runs through MARK and SPACE so mark starts are exactly BIT_PERIOD apart.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      bitcnt_d = bitcnt_q;
      per_d    = per_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (SEND) begin
               shift_d  = DATA_IN;
               bitcnt_d = 3'd0;
               per_d    = 32'd0;
               state_d  = S_MARK;
            end
         end
         S_MARK: begin
            per_d = per_q + 32'd1;
            if (per_q == mark_last) begin
               state_d = S_SPACE;
            end
         end
         S_SPACE: begin
            if (per_q == C_BP_LAST) begin
               per_d = 32'd0;
               if (bitcnt_q != 3'd7) begin
                  shift_d  = {1'b0, shift_q[7:1]};
                  bitcnt_d = bitcnt_q + 3'd1;
                  state_d  = S_MARK;
               end else begin
                  state_d = S_GAP;
               end
            end else begin
               per_d = per_q + 32'd1;
            end
         end
         S_GAP: begin
            if (per_q == C_GAP_LAST) begin
               per_d   = 32'd0;
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               per_d = per_q + 32'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      mark_d = (state_d == S_MARK);
      busy_d = (state_d != S_IDLE);
   end

   generate
      if (CARRIER_HALF == 0) begin : g_nocarrier
         always_comb begin
            car_d = 32'd0;
            led_d = mark_d;
         end
      end else begin : g_carrier
         localparam logic [31:0] C_CH_LAST = 32'(CARRIER_HALF - 1);
         // Phase restarts with LED on at every envelope rise.
         always_comb begin
            car_d = 32'd0;
            led_d = 1'b0;
            if (mark_d) begin
               if (!mark_q) begin
                  led_d = 1'b1;
               end else if (car_q == C_CH_LAST) begin
                  led_d = ~led_q;
               end else begin
                  car_d = car_q + 32'd1;
                  led_d = led_q;
               end
            end
         end
      end
   endgenerate

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= S_IDLE;
         shift_q  <= 8'd0;
         bitcnt_q <= 3'd0;
         per_q    <= 32'd0;
         car_q    <= 32'd0;
         mark_q   <= 1'b0;
         led_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         bitcnt_q <= bitcnt_d;
         per_q    <= per_d;
         car_q    <= car_d;
         mark_q   <= mark_d;
         led_q    <= led_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign BUSY     = busy_q;
   assign DONE     = done_q;
   assign MARK_ENV = mark_q;
   assign LED_OUT  = led_q;

endmodule
`default_nettype wire

// File: tb/tb_led_xmit.sv
`default_nettype none
// ============================================================================
// tb_led_xmit -- scoreboard bench for led_xmit with scaled timing parameters
// Rev 1.0
// ============================================================================
module tb_led_xmit;

   localparam int BP        = 40;
   localparam int ONE       = 24;
   localparam int ZERO      = 8;
   localparam int GAP       = 50;
   localparam int CH        = 3;
   localparam int SAMPLE_PT = (BP * 400) / 840;
   localparam int FRAME     = 8 * BP + GAP;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] data_in = 8'd0;
   logic       send = 1'b0;
   logic       busy, done, mark_env, led_out;
   logic       busy0, done0, mark_env0, led_out0;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   int          exp_w[$];
   logic [7:0]  exp_b[$];

   led_xmit #(
      .BIT_PERIOD(BP), .ONE_MARK(ONE), .ZERO_MARK(ZERO),
      .GAP_CYCLES(GAP), .CARRIER_HALF(CH)
   ) u_dut (
      .CLK(clk), .RESET(rst), .DATA_IN(data_in), .SEND(send),
      .BUSY(busy), .DONE(done), .MARK_ENV(mark_env), .LED_OUT(led_out)
   );

   led_xmit #(
      .BIT_PERIOD(BP), .ONE_MARK(ONE), .ZERO_MARK(ZERO),
      .GAP_CYCLES(GAP), .CARRIER_HALF(0)
   ) u_dut0 (
      .CLK(clk), .RESET(rst), .DATA_IN(data_in), .SEND(send),
      .BUSY(busy0), .DONE(done0), .MARK_ENV(mark_env0), .LED_OUT(led_out0)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Receiver model plus carrier/envelope checks, sampled on the falling edge.
   int         prev_me   = 0;
   int         last_rise = 0;
   int         first_rise = 0;
   int         bit_idx   = 0;
   logic [7:0] acc       = 8'd0;

   always @(negedge clk) begin
      if (rst) begin
         bit_idx = 0;
         acc     = 8'd0;
         prev_me = 0;
         exp_w.delete();
         exp_b.delete();
      end else begin
         if (mark_env && prev_me == 0) begin
            if (bit_idx == 0) first_rise = cyc;
            else check("rise_spacing", cyc - last_rise, BP);
            last_rise = cyc;
         end
         check("led_carrier", int'(led_out),
               int'(mark_env && (((cyc - last_rise) / CH) % 2 == 0)));
         check("led_nocarrier", int'(led_out0), int'(mark_env0));
         check("env_match", int'({mark_env0, busy0, done0}), int'({mark_env, busy, done}));
         if (!mark_env && prev_me == 1) begin
            int width;
            width = cyc - last_rise;
            check("mark_expected", int'(exp_w.size() > 0), 1);
            if (exp_w.size() > 0) check("mark_width", width, exp_w.pop_front());
            acc[bit_idx[2:0]] = (width > SAMPLE_PT);
            bit_idx++;
            if (bit_idx == 8) begin
               check("byte_expected", int'(exp_b.size() > 0), 1);
               if (exp_b.size() > 0) check("rx_byte", int'(acc), int'(exp_b.pop_front()));
               bit_idx = 0;
            end
         end
         if (done) begin
            check("done_time", cyc - first_rise, FRAME);
            check("busy_at_done", int'(busy), 0);
         end
         prev_me = int'(mark_env);
      end
   end

   task automatic push_exp(input logic [7:0] b);
      for (int i = 0; i < 8; i++) exp_w.push_back(b[i] ? ONE : ZERO);
      exp_b.push_back(b);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      data_in = b;
      send    = 1'b1;
      push_exp(b);
      @(posedge clk); #1;
      send    = 1'b0;
      data_in = 8'($urandom);
      check("busy_after_send", int'(busy), 1);
      check("mark_after_send", int'(mark_env), 1);
   endtask

   task automatic wait_done(input int bound);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < bound);
      check("done_seen", int'(done), 1);
   endtask

   initial begin
      int seen;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_mark", int'(mark_env), 0);
      check("rst_led",  int'(led_out), 0);
      rst = 1'b0;

      // Single frame 0xA5
      send_byte(8'hA5);
      wait_done(FRAME + 10);

      // Back-to-back 0x00 then 0xFF, second SEND in the DONE cycle
      send_byte(8'h00);
      wait_done(FRAME + 10);
      data_in = 8'hFF;
      send    = 1'b1;
      push_exp(8'hFF);
      @(posedge clk); #1;
      send = 1'b0;
      check("b2b_mark", int'(mark_env), 1);
      check("b2b_busy", int'(busy), 1);
      wait_done(FRAME + 10);

      // SEND while busy is ignored
      send_byte(8'h81);
      repeat (10) @(posedge clk);
      #1;
      data_in = 8'h3C;
      send    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("ignore_busy", int'(busy), 1);
      send = 1'b0;
      wait_done(FRAME + 10);
      repeat (2 * BP) @(negedge clk);
      check("no_extra_busy", int'(busy), 0);
      check("no_extra_mark", int'(mark_env), 0);

      // Reset during the third bit's mark
      send_byte(8'hC3);
      repeat (2 * BP + 3) @(posedge clk);
      #1;
      check("pre_rst_mark", int'(mark_env), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_led",  int'(led_out), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_done", int'(done), 0);
      check("midrst_mark", int'(mark_env), 0);
      seen = 0;
      repeat (FRAME) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      check("midrst_quiet", seen, 0);
      send_byte(8'h5A);
      wait_done(FRAME + 10);

      repeat (5) @(negedge clk);
      check("sb_marks_empty", exp_w.size(), 0);
      check("sb_bytes_empty", exp_b.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
